fight_round_ctrl: RTL
=====================

// Module: fight_round_ctrl
// PURPOSE
//  Match/round sequencer for the two-player fighting game.
//  - Gates player movement, tracks health and round wins, runs a pre-round countdown and the round clock.
//  - Applies hit events coming from the collision/attack logic.
//  - Sits beside the player-motion block: drives its move enable and a reposition pulse, and feeds the HUD.
// PARAMETERS
//  HEALTH_MAX       100  health at round start (fits 7 bits)
//  HIT_DAMAGE       10   health removed per accepted hit
//  HIT_COOLDOWN     30   frames after an accepted hit during which that attacker's further hits are ignored
//  COUNTDOWN_FRAMES 180  frames in the pre-round countdown (3 s at 60 Hz)
//  FRAMES_PER_SEC   60   frame_clk ticks per round-clock second
//  ROUND_SECONDS    60   round clock start value, in seconds
//  KO_HOLD_FRAMES   120  frames the round result is held before continuing
//  ROUNDS_TO_WIN    2    round wins needed to take the match
// PORTS
//  frame_clk     in   1  frame-rate clock; sole clock of the block
//  Reset         in   1  asynchronous, active-high reset
//  start         in   1  start/continue request, level; only rising edges are acted on
//  p1_hit        in   1  P1 landed a hit on P2 this frame
//  p2_hit        in   1  P2 landed a hit on P1 this frame
//  move_en       out  1  1 only in FIGHT; player motion must hold while 0
//  pos_reset     out  1  one-cycle pulse: return players to start positions
//  state         out  3  fight_pkg::state_t, for the HUD
//  p1_health     out  7  P1 health
//  p2_health     out  7  P2 health
//  p1_rounds     out  2  P1 rounds won
//  p2_rounds     out  2  P2 rounds won
//  round_sec     out  7  seconds left in the round
//  round_winner  out  2  fight_pkg::who_t: NONE/P1/P2/DRAW, winner of the last round
//  match_winner  out  2  fight_pkg::who_t, valid in MATCH_END, else NONE
// BEHAVIOUR
//  Reset values:
//  - state = IDLE; healths = HEALTH_MAX; rounds = 0; round_sec = ROUND_SECONDS.
//  - move_en = 0; pos_reset = 0; both winners = NONE; all counters and cooldowns = 0.
//  Start detection: start_rise = start & ~start_q, where start_q is a register cleared by Reset.
//  State machine, all transitions registered, 1-cycle latency:
//  - IDLE: on start_rise, go to COUNTDOWN, pulse pos_reset, load healths, rounds <= 0.
//  - COUNTDOWN: count COUNTDOWN_FRAMES frames, then go to FIGHT and load round_sec = ROUND_SECONDS.
//  - FIGHT:
//    - round_sec decrements every FRAMES_PER_SEC frames.
//    - The round ends when either health is 0, or when round_sec is 0 at the end of a second.
//  - ROUND_END:
//    - Hold for KO_HOLD_FRAMES frames.
//    - If either rounds count equals ROUNDS_TO_WIN, go to MATCH_END.
//    - Otherwise go to COUNTDOWN, pulse pos_reset, and reload both healths.
//  - MATCH_END: on start_rise, behave exactly as in IDLE.
//  Hits:
//  - Accepted only in FIGHT, only when the attacker's cooldown is 0.
//  - An accepted hit subtracts HIT_DAMAGE from the victim, saturating at 0, and loads the attacker's cooldown with HIT_COOLDOWN.
//  - Cooldowns count down every frame.
//  - p1_hit and p2_hit in the same frame: both are accepted independently; no priority between them.
//  Round result, decided on the cycle FIGHT exits:
//  - Exactly one health is 0: the other player wins.
//  - Both healths are 0 (simultaneous KO): DRAW.
//  - Timeout: the higher health wins; equal health gives DRAW.
//  - The winner's rounds count increments, saturating at 3; a DRAW awards nothing.
//  - round_winner holds its value until the next round ends, and is cleared to NONE on match start.
//  KO has priority over timeout in the same cycle: health-based decision; timeout-then-KO in one frame still uses that rule.
//  Reset mid-operation: every register returns to its reset value immediately, regardless of state.
// STRUCTURE
//  fight_pkg:
//  - typedef enum logic[2:0] state_t {IDLE, COUNTDOWN, FIGHT, ROUND_END, MATCH_END}.
//  - typedef enum logic[1:0] who_t {NONE, P1, P2, DRAW}.
//  - Widths HP_W = 7, RND_W = 2.
//  Sub-module hit_gate, instantiated once per attacker:
//  - Does cooldown counting and hit acceptance.
//  - Inputs: frame_clk, Reset, enable, hit. Output: accept.
//  One shared frame counter, reused for the countdown, the seconds tick and the KO hold.
// TESTING
//  1. Reset, start pulse: pos_reset high 1 cycle; move_en=0 for 180 frames, then 1; round_sec=60.
//  2. FIGHT, p1_hit held 61 frames: p2_health goes 100->90 (frame 1), 80 (frame 31), 70 (frame 61).
//  3. p1_hit and p2_hit in the same frame at 10/10 health: both become 0; round_winner=DRAW; no rounds awarded.
//  4. No hits for 60 s: at 3600 frames, round ends; healths equal, so DRAW; then after 120 frames, COUNTDOWN again.
//  5. P1 wins two rounds by KO: after the second ROUND_END hold, MATCH_END with match_winner=P1 and p1_rounds=2; start goes to COUNTDOWN with rounds=0.
//  6. Assert Reset mid-FIGHT, hit during COUNTDOWN: all outputs at reset values that same cycle; the hit is ignored, health stays 100.

Source files
------------

// File: rtl/fight_round_ctrl_pkg.sv
// Shared types, widths and arithmetic helpers for the fight round sequencer.
package fight_pkg;
  typedef enum logic [2:0] {IDLE, COUNTDOWN, FIGHT, ROUND_END, MATCH_END} state_t;
  typedef enum logic [1:0] {NONE, P1, P2, DRAW} who_t;

  localparam int HP_W  = 7;
  localparam int RND_W = 2;
  localparam int SEC_W = 7;

  function automatic logic [HP_W-1:0] hp_sub(logic [HP_W-1:0] hp, logic [HP_W-1:0] dmg);
    return (hp < dmg) ? '0 : hp - dmg;
  endfunction

  function automatic logic [RND_W-1:0] rnd_inc(logic [RND_W-1:0] r);
    return (r == '1) ? r : r + 1'b1;
  endfunction

  // KO and timeout share one rule: a single zero is simply the lower health.
  function automatic who_t judge(logic [HP_W-1:0] h1, logic [HP_W-1:0] h2);
    if (h1 > h2) return P1;
    if (h2 > h1) return P2;
    return DRAW;
  endfunction
endpackage

// File: rtl/fight_round_ctrl_if.sv
// Game-side control and HUD bus of the round sequencer.
interface fight_round_ctrl_if import fight_pkg::*; ();
  logic              start;
  logic              p1_hit;
  logic              p2_hit;
  logic              move_en;
  logic              pos_reset;
  state_t            state;
  logic [HP_W-1:0]   p1_health;
  logic [HP_W-1:0]   p2_health;
  logic [RND_W-1:0]  p1_rounds;
  logic [RND_W-1:0]  p2_rounds;
  logic [SEC_W-1:0]  round_sec;
  who_t              round_winner;
  who_t              match_winner;

  modport master (
    output start, p1_hit, p2_hit,
    input  move_en, pos_reset, state, p1_health, p2_health, p1_rounds, p2_rounds,
           round_sec, round_winner, match_winner
  );
  modport slave (
    input  start, p1_hit, p2_hit,
    output move_en, pos_reset, state, p1_health, p2_health, p1_rounds, p2_rounds,
           round_sec, round_winner, match_winner
  );
endinterface

// File: rtl/fight_round_ctrl_hit_gate.sv
// Per-attacker hit acceptance with a post-hit cooldown.
module hit_gate #(
  parameter int COOLDOWN = 30
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic enable,
  input  logic hit,
  output logic accept
);
  localparam int CD_W = $clog2(COOLDOWN + 1);

  logic [CD_W-1:0] cd;

  assign accept = enable & hit & (cd == '0);

  // The accepting frame is the first cooldown frame, so the next hit lands COOLDOWN frames later.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)            cd <= '0;
    else if (accept)      cd <= CD_W'(COOLDOWN - 1);
    else if (cd != '0)    cd <= cd - 1'b1;
  end
endmodule

// File: rtl/fight_round_ctrl.sv
// Match/round sequencer: countdown, round clock, health, round wins and match result.
module fight_round_ctrl import fight_pkg::*; #(
  parameter int HEALTH_MAX       = 100,
  parameter int HIT_DAMAGE       = 10,
  parameter int HIT_COOLDOWN     = 30,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int FRAMES_PER_SEC   = 60,
  parameter int ROUND_SECONDS    = 60,
  parameter int KO_HOLD_FRAMES   = 120,
  parameter int ROUNDS_TO_WIN    = 2
) (
  input logic               frame_clk,
  input logic               Reset,
  fight_round_ctrl_if.slave bus
);
  localparam int FRAME_MAX = (COUNTDOWN_FRAMES > KO_HOLD_FRAMES)
                           ? ((COUNTDOWN_FRAMES > FRAMES_PER_SEC) ? COUNTDOWN_FRAMES : FRAMES_PER_SEC)
                           : ((KO_HOLD_FRAMES > FRAMES_PER_SEC) ? KO_HOLD_FRAMES : FRAMES_PER_SEC);
  localparam int CNT_W = $clog2(FRAME_MAX + 1);

  localparam logic [HP_W-1:0]  HP_FULL = HP_W'(HEALTH_MAX);
  localparam logic [HP_W-1:0]  HP_DMG  = HP_W'(HIT_DAMAGE);
  localparam logic [SEC_W-1:0] SEC_RLD = SEC_W'(ROUND_SECONDS);
  localparam logic [RND_W-1:0] RND_WIN = RND_W'(ROUNDS_TO_WIN);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(FRAMES_PER_SEC - 1);
  localparam logic [CNT_W-1:0] KO_LAST = CNT_W'(KO_HOLD_FRAMES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HP_W-1:0]   hp1_q, hp1_d, hp2_q, hp2_d, hp1_hit, hp2_hit;
  logic [RND_W-1:0]  rnd1_q, rnd1_d, rnd2_q, rnd2_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  who_t              rwin_q, rwin_d, win;
  logic              pos_rst_q, pos_rst_d;
  logic              start_q, start_rise;
  logic              tick, timeout, ko;
  logic [1:0]        acc;

  assign start_rise = bus.start & ~start_q;

  // acc[0]: P1 attacking P2, acc[1]: P2 attacking P1.
  hit_gate #(.COOLDOWN(HIT_COOLDOWN)) u_hit_gate [1:0] (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .enable    (state_q == FIGHT),
    .hit       ({bus.p2_hit, bus.p1_hit}),
    .accept    (acc)
  );

  assign hp2_hit = acc[0] ? hp_sub(hp2_q, HP_DMG) : hp2_q;
  assign hp1_hit = acc[1] ? hp_sub(hp1_q, HP_DMG) : hp1_q;

  // Round ends on the killing frame, judged on post-hit health.
  assign tick    = (cnt_q == SEC_LAST);
  assign timeout = tick && (sec_q <= SEC_W'(1));
  assign ko      = (hp1_hit == '0) || (hp2_hit == '0);
  assign win     = judge(hp1_hit, hp2_hit);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hp1_d     = hp1_hit;
    hp2_d     = hp2_hit;
    rnd1_d    = rnd1_q;
    rnd2_d    = rnd2_q;
    sec_d     = sec_q;
    rwin_d    = rwin_q;
    pos_rst_d = 1'b0;
    case (state_q)
      IDLE, MATCH_END: begin
        if (start_rise) begin
          state_d   = COUNTDOWN;
          cnt_d     = '0;
          hp1_d     = HP_FULL;
          hp2_d     = HP_FULL;
          rnd1_d    = '0;
          rnd2_d    = '0;
          sec_d     = SEC_RLD;
          rwin_d    = NONE;
          pos_rst_d = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (cnt_q == CD_LAST) begin
          state_d = FIGHT;
          cnt_d   = '0;
          sec_d   = SEC_RLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIGHT: begin
        if (tick) begin
          cnt_d = '0;
          sec_d = (sec_q == '0) ? '0 : sec_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (ko || timeout) begin
          state_d = ROUND_END;
          cnt_d   = '0;
          rwin_d  = win;
          if (win == P1) rnd1_d = rnd_inc(rnd1_q);
          if (win == P2) rnd2_d = rnd_inc(rnd2_q);
        end
      end
      ROUND_END: begin
        if (cnt_q == KO_LAST) begin
          cnt_d = '0;
          if (rnd1_q == RND_WIN || rnd2_q == RND_WIN) begin
            state_d = MATCH_END;
          end else begin
            state_d   = COUNTDOWN;
            hp1_d     = HP_FULL;
            hp2_d     = HP_FULL;
            pos_rst_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hp1_q     <= HP_FULL;
      hp2_q     <= HP_FULL;
      rnd1_q    <= '0;
      rnd2_q    <= '0;
      sec_q     <= SEC_RLD;
      rwin_q    <= NONE;
      pos_rst_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hp1_q     <= hp1_d;
      hp2_q     <= hp2_d;
      rnd1_q    <= rnd1_d;
      rnd2_q    <= rnd2_d;
      sec_q     <= sec_d;
      rwin_q    <= rwin_d;
      pos_rst_q <= pos_rst_d;
      start_q   <= bus.start;
    end
  end

  assign bus.state        = state_q;
  assign bus.move_en      = (state_q == FIGHT);
  assign bus.pos_reset    = pos_rst_q;
  assign bus.p1_health    = hp1_q;
  assign bus.p2_health    = hp2_q;
  assign bus.p1_rounds    = rnd1_q;
  assign bus.p2_rounds    = rnd2_q;
  assign bus.round_sec    = sec_q;
  assign bus.round_winner = rwin_q;
  assign bus.match_winner = (state_q != MATCH_END) ? NONE
                          : (rnd1_q == RND_WIN)   ? P1
                          : (rnd2_q == RND_WIN)   ? P2 : NONE;
endmodule
